outport_rr_mux: RTL

Parametrised successor to the router output-port multiplexer. It merges `no_inport` input-port data streams onto one output link. Arbitration is internal: round-robin with packet lock, replacing the external one-hot select. The block adds an idle-timeout watchdog that frees a grant held by a stalled input. It sits between the input-port buffers and the output link driver in each router, one instance per output port.

---
 rtl/outport_rr_mux_pkg.sv | 17 +
 rtl/outport_rr_mux_if.sv | 34 +++
 rtl/outport_rr_mux_rr_arbiter.sv | 32 +++
 rtl/outport_rr_mux.sv | 87 ++++++++
 4 files changed

// File: rtl/outport_rr_mux_pkg.sv
// Shared router parameters and helpers for the output-port round-robin mux.
package outport_rr_mux_pkg;

    localparam int PHIT_SIZE      = 16;
    localparam int NO_INPORT      = 6;
    localparam int TIMEOUT_CYCLES = 64;

    // Index of the set bit of a one-hot vector; 0 when nothing is set.
    function automatic int unsigned onehot_to_idx(input logic [31:0] oh);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < 32; i++)
            if (oh[i]) idx = i;
        return idx;
    endfunction

endpackage

// File: rtl/outport_rr_mux_if.sv
// Input-port / output-link bundle seen by one output-port mux.
interface outport_rr_mux_if
    import outport_rr_mux_pkg::*;
#(
    parameter int phit_size = PHIT_SIZE,
    parameter int no_inport = NO_INPORT
) ();

    logic                                 en;
    logic [no_inport-1:0]                 reqs;
    logic [no_inport-1:0][phit_size-1:0]  outdatas;
    logic [no_inport-1:0]                 news;
    logic [no_inport-1:0]                 sent_reqs;
    logic                                 ready;
    logic [no_inport-1:0]                 readies;
    logic [phit_size-1:0]                 data;
    // Phit-valid flag on data; "new" itself is a reserved word.
    logic                                 new_phit;
    logic                                 sent_req;
    logic                                 release_sig;
    logic [no_inport-1:0]                 grant;
    logic                                 timeout_err;

    modport master (
        output en, reqs, outdatas, news, sent_reqs, ready,
        input  readies, data, new_phit, sent_req, release_sig, grant, timeout_err
    );

    modport slave (
        input  en, reqs, outdatas, news, sent_reqs, ready,
        output readies, data, new_phit, sent_req, release_sig, grant, timeout_err
    );

endinterface

// File: rtl/outport_rr_mux_rr_arbiter.sv
// Combinational round-robin pick: first request at or above rr_ptr, with wrap.
module rr_arbiter
    import outport_rr_mux_pkg::*;
#(
    parameter  int no_inport = NO_INPORT,
    localparam int PW        = (no_inport > 1) ? $clog2(no_inport) : 1
) (
    input  logic [no_inport-1:0] reqs,
    input  logic [PW-1:0]        rr_ptr,
    input  logic                 en,
    output logic [no_inport-1:0] win,
    output logic [PW-1:0]        win_idx
);

    int j;

    // Scan farthest-first so the candidate closest to rr_ptr overwrites the rest.
    always_comb begin
        win = '0;
        j   = 0;
        for (int k = no_inport - 1; k >= 0; k--) begin
            j = int'(rr_ptr) + k;
            if (j >= no_inport) j = j - no_inport;
            if (en && reqs[j]) begin
                win    = '0;
                win[j] = 1'b1;
            end
        end
        win_idx = PW'(onehot_to_idx(32'(win)));
    end

endmodule

// File: rtl/outport_rr_mux.sv
// Output-port mux: round-robin packet-locked arbitration, two-stage ready/data
// pipeline and an idle watchdog that reclaims a grant from a stalled input.
module outport_rr_mux
    import outport_rr_mux_pkg::*;
#(
    parameter int phit_size      = PHIT_SIZE,
    parameter int no_inport      = NO_INPORT,
    parameter int timeout_cycles = TIMEOUT_CYCLES
) (
    input logic              clk,
    input logic              rs,
    outport_rr_mux_if.slave  bus
);

    localparam int PW = (no_inport > 1) ? $clog2(no_inport) : 1;
    localparam int TW = (timeout_cycles > 0) ? $clog2(timeout_cycles + 1) : 1;
    localparam logic [TW-1:0] TC   = TW'(timeout_cycles);
    localparam logic [PW-1:0] LAST = PW'(no_inport - 1);

    logic                 locked, data_en, timeout_err_q;
    logic [no_inport-1:0] grant_q, data_select, win;
    logic [PW-1:0]        rr_ptr, win_idx;
    logic [TW-1:0]        timer;
    logic [1:0]           rs_hold;
    logic                 new_phit, sent_req, release_sig, wd_hit, forced;
    logic [phit_size-1:0] mux;

    rr_arbiter #(.no_inport(no_inport)) u_arb (
        .reqs    (bus.reqs),
        .rr_ptr  (rr_ptr),
        .en      (bus.en & ~locked),
        .win     (win),
        .win_idx (win_idx)
    );

    always_comb begin
        mux = '0;
        for (int i = 0; i < no_inport; i++)
            mux = mux | (bus.outdatas[i] & {phit_size{data_select[i]}});
    end

    assign new_phit    = data_en & |(bus.news & data_select);
    assign sent_req    = data_en & |(bus.sent_reqs & data_select) & ~rs & ~|rs_hold;
    assign release_sig = new_phit & ~sent_req;
    // A tail landing on the terminal count is an ordinary release.
    assign wd_hit      = (timeout_cycles != 0) && locked && (timer == TC);
    assign forced      = wd_hit & ~release_sig;

    always_ff @(posedge clk) begin
        if (rs) begin
            locked        <= 1'b0;
            grant_q       <= '0;
            rr_ptr        <= '0;
            data_en       <= 1'b0;
            data_select   <= '0;
            timer         <= '0;
            timeout_err_q <= 1'b0;
            rs_hold       <= 2'b11;
        end else begin
            rs_hold       <= {rs_hold[0], 1'b0};
            data_en       <= locked & bus.en & ~release_sig & ~forced;
            data_select   <= grant_q;
            timeout_err_q <= forced;

            if (!locked || new_phit || forced) timer <= '0;
            else if (bus.en && data_en)        timer <= timer + TW'(1);

            if (release_sig || forced) begin
                locked  <= 1'b0;
                grant_q <= '0;
            end else if (!locked && bus.en && |bus.reqs) begin
                locked  <= 1'b1;
                grant_q <= win;
                rr_ptr  <= (win_idx == LAST) ? '0 : win_idx + 1'b1;
            end
        end
    end

    assign bus.readies     = (locked & bus.en & bus.ready) ? grant_q : '0;
    assign bus.data        = new_phit ? mux : '0;
    assign bus.new_phit    = new_phit;
    assign bus.sent_req    = sent_req;
    assign bus.release_sig = release_sig;
    assign bus.grant       = grant_q;
    assign bus.timeout_err = timeout_err_q;

endmodule
